// File: rtl/apb_pwm_deadtime_if.sv
// APB request/response bundle for the dead-time PWM block.
interface apb_pwm_deadtime_if #(
    parameter int APB_ADDR_WIDTH = 12
) ();
    logic [APB_ADDR_WIDTH-1:0] PADDR;
    logic [31:0]               PWDATA;
    logic                      PWRITE;
    logic                      PSEL;
    logic                      PENABLE;
    logic [31:0]               PRDATA;
    logic                      PREADY;
    logic                      PSLVERR;

    modport master (
        output PADDR, PWDATA, PWRITE, PSEL, PENABLE,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PADDR, PWDATA, PWRITE, PSEL, PENABLE,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_pwm_deadtime.sv
// Complementary high/low gate drive with programmable rise/fall dead time
// per channel, configured over a zero-wait-state APB register file.
//
// state  | meaning
// IDLE   | channel disabled, both drives off
// DEAD_R | rising dead time counting down before high-side turns on
// HIGH   | high-side drive on
// DEAD_F | falling dead time counting down before low-side turns on
// LOW    | low-side drive on
module apb_pwm_deadtime #(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int PWM_CNT        = 4
) (
    input  logic               HCLK,
    input  logic               HRESET,
    apb_pwm_deadtime_if.slave  apb,
    input  logic [PWM_CNT-1:0] pwm_i,
    output logic [PWM_CNT-1:0] pwm_hi_o,
    output logic [PWM_CNT-1:0] pwm_lo_o
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DEAD_R = 3'd1,
        S_HIGH   = 3'd2,
        S_DEAD_F = 3'd3,
        S_LOW    = 3'd4
    } state_t;

    logic [PWM_CNT-1:0]        r_ctrl;
    logic [15:0]               r_deadtime;
    logic [PWM_CNT-1:0]        r_status;

    logic [APB_ADDR_WIDTH-1:0] w_paddr;
    logic [1:0]                w_addr;
    logic                      w_access;
    logic                      w_wr;
    logic [PWM_CNT-1:0]        w_sts_set;
    logic [PWM_CNT-1:0]        w_sts_clr;
    logic [31:0]               w_rdata;
    logic [7:0]                w_rise;
    logic [7:0]                w_fall;
    logic                      w_unused;

    assign w_paddr  = apb.PADDR;
    assign w_addr   = w_paddr[3:2];
    assign w_access = apb.PSEL & apb.PENABLE;
    assign w_wr     = w_access & apb.PWRITE;
    assign w_rise   = r_deadtime[7:0];
    assign w_fall   = r_deadtime[15:8];
    assign w_unused = &{1'b0, w_paddr, apb.PWDATA};

    assign w_sts_clr = (w_wr && w_addr == 2'd2) ? apb.PWDATA[PWM_CNT-1:0] : '0;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_ctrl     <= '0;
            r_deadtime <= '0;
            r_status   <= '0;
        end else begin
            if (w_wr && w_addr == 2'd0) r_ctrl <= apb.PWDATA[PWM_CNT-1:0];
            if (w_wr && w_addr == 2'd1) r_deadtime <= apb.PWDATA[15:0];
            // a new short-pulse event beats a simultaneous W1C of the same bit
            r_status <= (r_status & ~w_sts_clr) | w_sts_set;
        end
    end

    always_comb begin
        w_rdata = '0;
        if (apb.PSEL && !apb.PWRITE && !HRESET) begin
            case (w_addr)
                2'd0:    w_rdata[PWM_CNT-1:0] = r_ctrl;
                2'd1:    w_rdata[15:0]        = r_deadtime;
                2'd2:    w_rdata[PWM_CNT-1:0] = r_status;
                default: w_rdata              = '0;
            endcase
        end
    end

    assign apb.PRDATA  = w_rdata;
    assign apb.PREADY  = 1'b1;
    assign apb.PSLVERR = w_access & (w_addr == 2'd3) & ~HRESET;

    for (genvar k = 0; k < PWM_CNT; k++) begin : g_ch
        state_t     r_state;
        logic [7:0] r_cnt;
        logic       r_hi;
        logic       r_lo;

        // outputs are registered from the next state so they change with it
        always_ff @(posedge HCLK) begin
            if (HRESET || !r_ctrl[k]) begin
                r_state <= S_IDLE;
                r_cnt   <= 8'd0;
                r_hi    <= 1'b0;
                r_lo    <= 1'b0;
            end else begin
                r_hi <= 1'b0;
                r_lo <= 1'b0;
                case (r_state)
                    S_IDLE: begin
                        if (pwm_i[k]) begin
                            r_state <= S_DEAD_R;
                            r_cnt   <= w_rise;
                        end else begin
                            r_state <= S_DEAD_F;
                            r_cnt   <= w_fall;
                        end
                    end
                    S_DEAD_R: begin
                        if (!pwm_i[k]) begin
                            r_state <= S_DEAD_F;
                            r_cnt   <= w_fall;
                        end else if (r_cnt == 8'd0) begin
                            r_state <= S_HIGH;
                            r_hi    <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt - 8'd1;
                        end
                    end
                    S_HIGH: begin
                        if (!pwm_i[k]) begin
                            r_state <= S_DEAD_F;
                            r_cnt   <= w_fall;
                        end else begin
                            r_hi <= 1'b1;
                        end
                    end
                    S_DEAD_F: begin
                        if (pwm_i[k]) begin
                            r_state <= S_DEAD_R;
                            r_cnt   <= w_rise;
                        end else if (r_cnt == 8'd0) begin
                            r_state <= S_LOW;
                            r_lo    <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt - 8'd1;
                        end
                    end
                    S_LOW: begin
                        if (pwm_i[k]) begin
                            r_state <= S_DEAD_R;
                            r_cnt   <= w_rise;
                        end else begin
                            r_lo <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_cnt   <= 8'd0;
                    end
                endcase
            end
        end

        // input reversed before the dead time expired: pulse too short to pass
        assign w_sts_set[k] = r_ctrl[k] &
                              (((r_state == S_DEAD_R) & ~pwm_i[k]) |
                               ((r_state == S_DEAD_F) &  pwm_i[k]));
        assign pwm_hi_o[k]  = r_hi;
        assign pwm_lo_o[k]  = r_lo;
    end
endmodule

// File: tb/tb_apb_pwm_deadtime.sv
// Scoreboard bench: stimulus queues hand-computed expectations, a negedge
// monitor compares APB access-phase responses and per-cycle PWM outputs.
module tb_apb_pwm_deadtime;
    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } apb_exp_t;

    typedef struct {
        int         cyc;
        logic [7:0] v;
    } pwm_exp_t;

    logic       HCLK = 1'b0;
    logic       HRESET;
    logic [3:0] pwm;
    logic [3:0] pwm_hi_o;
    logic [3:0] pwm_lo_o;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    apb_exp_t apb_q[$];
    pwm_exp_t pwm_q[$];
    apb_exp_t ea;
    pwm_exp_t ep;

    apb_pwm_deadtime_if #(.APB_ADDR_WIDTH(12)) bus ();

    apb_pwm_deadtime #(
        .APB_ADDR_WIDTH(12),
        .PWM_CNT(4)
    ) dut (
        .HCLK(HCLK),
        .HRESET(HRESET),
        .apb(bus),
        .pwm_i(pwm),
        .pwm_hi_o(pwm_hi_o),
        .pwm_lo_o(pwm_lo_o)
    );

    always #5 HCLK = ~HCLK;
    always @(posedge HCLK) cyc <= cyc + 1;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_chk++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s at cycle %0d: got 0x%08h expected 0x%08h", nm, cyc, act, exp_v);
    endfunction

    always @(negedge HCLK) begin
        chk("no_overlap", {28'h0, pwm_hi_o & pwm_lo_o}, 32'h0);
        if (bus.PSEL && bus.PENABLE) begin
            if (apb_q.size() == 0) begin
                chk("apb_unexpected", 32'h1, 32'h0);
            end else begin
                ea = apb_q.pop_front();
                chk("prdata", bus.PRDATA, ea.rdata);
                chk("pslverr", {31'h0, bus.PSLVERR}, {31'h0, ea.err});
                chk("pready", {31'h0, bus.PREADY}, 32'h1);
            end
        end
        while (pwm_q.size() > 0 && pwm_q[0].cyc <= cyc) begin
            ep = pwm_q.pop_front();
            if (ep.cyc < cyc) chk("pwm_missed", 32'(cyc), 32'(ep.cyc));
            else chk("pwm_hi_lo", {24'h0, pwm_hi_o, pwm_lo_o}, {24'h0, ep.v});
        end
    end

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // expect {hi,lo} == v after every edge in [from, to]
    task automatic exp_pwm(input int from, input int to, input logic [7:0] v);
        for (int c = from; c <= to; c++) pwm_q.push_back('{c, v});
    endtask

    task automatic apb_write(input logic [11:0] a, input logic [31:0] d, input logic exp_err);
        apb_q.push_back('{32'h0, exp_err});
        bus.PADDR   = a;
        bus.PWDATA  = d;
        bus.PWRITE  = 1'b1;
        bus.PSEL    = 1'b1;
        bus.PENABLE = 1'b0;
        tick();
        bus.PENABLE = 1'b1;
        tick();
        bus.PSEL    = 1'b0;
        bus.PENABLE = 1'b0;
        bus.PWRITE  = 1'b0;
    endtask

    task automatic apb_read(input logic [11:0] a, input logic [31:0] exp_d, input logic exp_err);
        apb_q.push_back('{exp_d, exp_err});
        bus.PADDR   = a;
        bus.PWRITE  = 1'b0;
        bus.PSEL    = 1'b1;
        bus.PENABLE = 1'b0;
        tick();
        bus.PENABLE = 1'b1;
        tick();
        bus.PSEL    = 1'b0;
        bus.PENABLE = 1'b0;
    endtask

    initial begin
        int n;
        HRESET      = 1'b1;
        pwm         = 4'h0;
        bus.PADDR   = '0;
        bus.PWDATA  = '0;
        bus.PWRITE  = 1'b0;
        bus.PSEL    = 1'b0;
        bus.PENABLE = 1'b0;
        ticks(3);
        HRESET = 1'b0;

        // reset state
        exp_pwm(cyc + 1, cyc + 2, 8'h00);
        apb_read(12'h000, 32'h0, 1'b0);
        apb_read(12'h004, 32'h0, 1'b0);
        apb_read(12'h008, 32'h0, 1'b0);

        // register masking and the unmapped offset
        apb_write(12'h000, 32'hABCD_EF5A, 1'b0);
        apb_read(12'h000, 32'h0000_000A, 1'b0);
        apb_write(12'h004, 32'h1234_5678, 1'b0);
        apb_read(12'h004, 32'h0000_5678, 1'b0);
        apb_write(12'h00C, 32'hFFFF_FFFF, 1'b1);
        apb_read(12'h00C, 32'h0, 1'b1);
        apb_read(12'h000, 32'h0000_000A, 1'b0);
        apb_read(12'h004, 32'h0000_5678, 1'b0);
        apb_read(12'h008, 32'h0, 1'b0);
        apb_write(12'h000, 32'h0, 1'b0);
        ticks(2);

        // RISE_DT=2, FALL_DT=3 square wave on channel 0
        apb_write(12'h004, 32'h0000_0302, 1'b0);
        apb_write(12'h000, 32'h0000_0001, 1'b0);
        exp_pwm(cyc + 1, cyc + 4, 8'h00);
        exp_pwm(cyc + 5, cyc + 5, 8'h01);
        ticks(6);
        for (int p = 0; p < 2; p++) begin
            pwm = 4'h1;
            exp_pwm(cyc + 1, cyc + 3, 8'h00);
            exp_pwm(cyc + 4, cyc + 10, 8'h10);
            ticks(10);
            pwm = 4'h0;
            exp_pwm(cyc + 1, cyc + 4, 8'h00);
            exp_pwm(cyc + 5, cyc + 10, 8'h01);
            ticks(10);
        end

        // RISE_DT=5, 2-cycle pulse from LOW is swallowed and flagged
        apb_write(12'h004, 32'h0000_0005, 1'b0);
        pwm = 4'h1;
        exp_pwm(cyc + 1, cyc + 3, 8'h00);
        exp_pwm(cyc + 4, cyc + 6, 8'h01);
        ticks(2);
        pwm = 4'h0;
        ticks(4);
        apb_read(12'h008, 32'h0000_0001, 1'b0);
        apb_write(12'h008, 32'h0000_0001, 1'b0);
        apb_read(12'h008, 32'h0, 1'b0);

        // zero dead time: one-cycle break-before-make each way
        apb_write(12'h004, 32'h0, 1'b0);
        for (int p = 0; p < 4; p++) begin
            pwm = 4'h1;
            exp_pwm(cyc + 1, cyc + 1, 8'h00);
            exp_pwm(cyc + 2, cyc + 3, 8'h10);
            ticks(3);
            pwm = 4'h0;
            exp_pwm(cyc + 1, cyc + 1, 8'h00);
            exp_pwm(cyc + 2, cyc + 3, 8'h01);
            ticks(3);
        end

        // all channels HIGH, disable, re-enable
        apb_write(12'h004, 32'h0000_0302, 1'b0);
        apb_write(12'h000, 32'h0000_000F, 1'b0);
        pwm = 4'hF;
        ticks(10);
        exp_pwm(cyc + 1, cyc + 1, 8'hF0);
        tick();
        apb_write(12'h000, 32'h0, 1'b0);
        exp_pwm(cyc + 1, cyc + 3, 8'h00);
        ticks(3);
        apb_write(12'h000, 32'h0000_000F, 1'b0);
        exp_pwm(cyc + 1, cyc + 3, 8'h00);
        exp_pwm(cyc + 4, cyc + 5, 8'hF0);
        ticks(5);

        // reset while channel 0 sits in DEAD_R with cnt=4
        apb_write(12'h000, 32'h0, 1'b0);
        pwm = 4'h1;
        apb_write(12'h004, 32'h0000_0006, 1'b0);
        apb_write(12'h000, 32'h0000_0001, 1'b0);
        n = cyc;
        exp_pwm(n + 1, n + 12, 8'h00);
        ticks(3);
        HRESET      = 1'b1;
        bus.PADDR   = 12'h000;
        bus.PWRITE  = 1'b0;
        bus.PSEL    = 1'b1;
        bus.PENABLE = 1'b1;
        apb_q.push_back('{32'h0, 1'b0});
        tick();
        HRESET      = 1'b0;
        bus.PSEL    = 1'b0;
        bus.PENABLE = 1'b0;
        ticks(8);
        apb_read(12'h000, 32'h0, 1'b0);
        apb_read(12'h004, 32'h0, 1'b0);
        apb_read(12'h008, 32'h0, 1'b0);
        ticks(2);

        chk("apb_sb_drained", 32'(apb_q.size()), 32'h0);
        chk("pwm_sb_drained", 32'(pwm_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
